lcd_msg_assembler: RTL and testbench
====================================

// Module: lcd_msg_assembler
// PURPOSE
//  Assembles UART RX bytes into one packed text message and a length for the LCD
//  display stage (its mess / length_of_string inputs).
//  A message ends on CR/LF or after an idle timeout. Backspace edits the message
//  in progress. Each finished message is published atomically as one register update.
// PARAMETERS
//  MAX_LEN      61          max characters held; oMESS width is MAX_LEN*8+1
//  TIMEOUT_CYC  50_000_000  idle cycles in RECV before auto-publish (1 s @ 50 MHz)
// PORTS
//  iCLK        in   1            system clock; single clock domain
//  iRST_N      in   1            asynchronous, active-low reset
//  iRX_DATA    in   8            received byte; valid only when iRX_VALID=1
//  iRX_VALID   in   1            1-cycle strobe from the UART receiver
//  iRX_ERR     in   1            1-cycle framing/parity error strobe
//  oMESS       out  MAX_LEN*8+1  published message; last char in [7:0], MSB bit always 0
//  oLENGTH     out  9            character count of oMESS (0..MAX_LEN)
//  oMSG_VALID  out  1            1-cycle pulse when oMESS/oLENGTH update
//  oBUSY       out  1            1 while in RECV or DROP
//  oOVERFLOW   out  1            1 if the last published message was truncated
//  oERR_CNT    out  8            saturating count of iRX_ERR strobes
// BEHAVIOUR
//  Reset (async, iRST_N=0): all outputs 0; state IDLE; work reg, count, timer = 0.
//  States:
//   IDLE: waits for a byte.
//   RECV: accumulates characters.
//   DROP: discards characters after overflow.
//   PUB:  one cycle; publishes the message.
//  Byte classes: CR=8'h0D, LF=8'h0A (terminators); BS=8'h08; NUL=8'h00; all others printable.
//  Append: work <= {work[MAX_LEN*8-9:0], byte}; count <= count+1; timer cleared.
//  IDLE: printable -> append, go RECV. Terminator, BS and NUL are ignored.
//  RECV:
//   - printable with count<MAX_LEN -> append.
//   - printable with count==MAX_LEN -> set trunc flag, go DROP; byte discarded.
//   - BS: if count>0, work <= work>>8 and count-1. If the new count is 0, go IDLE.
//   - terminator -> PUB.
//   - NUL -> ignored.
//   - no byte -> timer+1; when timer==TIMEOUT_CYC-1 -> PUB.
//  DROP: every byte except a terminator is discarded, BS included. Terminator -> PUB.
//   DROP has no timeout.
//  PUB, registered at cycle N+1 after the terminator or timeout at cycle N:
//   - oMESS <= {1'b0, work}; oLENGTH <= count; oOVERFLOW <= trunc.
//   - oMSG_VALID=1 for exactly that cycle.
//   - Then clear work, count, trunc and timer, and go IDLE.
//   - A byte that arrives during PUB is handled as if in IDLE.
//  Empty messages are never published. So CR followed by LF gives one publish, not two.
//  iRX_ERR, in any state:
//   - oERR_CNT+1, saturating at 8'hFF.
//   - Discard work, count and trunc; go IDLE.
//   - oMESS/oLENGTH keep their last published values.
//  iRX_ERR and iRX_VALID in the same cycle: the error wins and the byte is dropped.
//  oMESS, oLENGTH and oOVERFLOW change only in PUB and at reset. They are stable for the
//   display stage's periodic sampling.
//  oBUSY is a registered decode of state: 1 in RECV or DROP.
//  Reset mid-message: immediate return to the reset values.
//   The previous oMESS is lost (it becomes 0).
//  Timer width: $clog2(TIMEOUT_CYC). Count width: 9 bits. There is no count wrap,
//   because the overflow path limits count to MAX_LEN.
// STRUCTURE
//  Shared package lcd_defs: CHAR_CR, CHAR_LF, CHAR_BS, CHAR_NUL, LCD_MSG_MAX_LEN=61,
//   and the state encoding (IDLE=0, RECV=1, DROP=2, PUB=3).
//  One sub-module, lcd_idle_timer: counter with clear/enable inputs and an expire pulse,
//   parameterised by TIMEOUT_CYC.
//  The rest is a single FSM plus datapath in this file.
// TESTING (bench uses TIMEOUT_CYC=100)
//  1. "HI" then CR ->
//     - oMSG_VALID pulses 1 cycle after CR, with oLENGTH=2 and oMESS[15:0]=16'h4849.
//     - Upper bits of oMESS = 0.
//     - oOVERFLOW=0.
//  2. "ABC", BS, "D", LF -> oLENGTH=3, oMESS[23:0]=24'h414244.
//     Then a second LF -> no new oMSG_VALID.
//  3. 65 chars 'a'..., then CR ->
//     - oBUSY stays 1 through DROP.
//     - Publish gives oLENGTH=61, last char = the 61st byte, oOVERFLOW=1.
//     - Next "x" CR gives oOVERFLOW=0.
//  4. "OK", then idle ->
//     - oMSG_VALID exactly 100 cycles after the 'K' strobe, with oLENGTH=2.
//     - DROP-state idle -> no publish.
//  5. "AB", then iRX_ERR together with iRX_VALID('C'), then CR ->
//     - No publish; oERR_CNT=1.
//     - oMESS still holds the previous message.
//     - 300 errors saturate oERR_CNT at 255.
//  6. iRST_N low mid-message (after "XY") -> all outputs 0 immediately.
//     After release, "Z" CR -> oLENGTH=1, oMESS[7:0]=8'h5A.

Source files
------------

// File: rtl/lcd_defs_pkg.sv
// Shared constants for the LCD message path: byte classes, message size and FSM encoding.
package lcd_defs;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_NUL = 8'h00;

  localparam int unsigned LCD_MSG_MAX_LEN = 61;
  localparam int unsigned LCD_CNT_W       = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_PUB  = 2'd3;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CHAR_CR) || (b == CHAR_LF);
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return !(is_term(b) || (b == CHAR_BS) || (b == CHAR_NUL));
  endfunction

endpackage

// File: rtl/lcd_idle_timer.sv
// Idle-cycle counter: clear has priority over enable; expire_c flags the last counted cycle.
module lcd_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Expire is independent of clr so the parent can use it to decide the clear.
  assign expire_c = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_msg_assembler.sv
// Collects UART RX bytes into a packed text message for the LCD stage and publishes
// each finished message (terminator or idle timeout) as one atomic register update.
module lcd_msg_assembler
  import lcd_defs::*;
#(
  parameter int unsigned MAX_LEN     = LCD_MSG_MAX_LEN,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [7:0]           iRX_DATA,
  input  logic                 iRX_VALID,
  input  logic                 iRX_ERR,
  output logic [MAX_LEN*8:0]   oMESS,
  output logic [8:0]           oLENGTH,
  output logic                 oMSG_VALID,
  output logic                 oBUSY,
  output logic                 oOVERFLOW,
  output logic [7:0]           oERR_CNT
);

  localparam int unsigned WORK_W = MAX_LEN * 8;
  localparam int unsigned CNT_W  = LCD_CNT_W;

  logic [1:0]        state_q, state_d;
  logic [WORK_W-1:0] work_q, work_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              trunc_q, trunc_d;
  logic [WORK_W:0]   mess_q, mess_d;
  logic [CNT_W-1:0]  length_q, length_d;
  logic              msg_valid_q, msg_valid_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic tmr_clr_c, tmr_en_c, tmr_expire_c;
  logic append_c, publish_c;

  assign tmr_en_c = (state_q == ST_RECV) && !iRX_VALID && !iRX_ERR;

  lcd_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk      (iCLK),
    .rst_n    (iRST_N),
    .clr      (tmr_clr_c),
    .en       (tmr_en_c),
    .expire_c (tmr_expire_c)
  );

  // Next-state and datapath; outputs are loaded on the edge that enters PUB.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
    mess_d      = mess_q;
    length_d    = length_q;
    ovf_d       = ovf_q;
    msg_valid_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    tmr_clr_c   = 1'b1;
    append_c    = 1'b0;
    publish_c   = 1'b0;

    if (iRX_ERR) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      work_d  = '0;
      count_d = '0;
      trunc_d = 1'b0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (!iRX_VALID) begin
            if (tmr_expire_c) begin
              publish_c = 1'b1;
            end else begin
              tmr_clr_c = 1'b0;
            end
          end else if (is_term(iRX_DATA)) begin
            publish_c = 1'b1;
          end else if (iRX_DATA == CHAR_BS) begin
            work_d  = work_q >> 8;
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
            end
          end else if (iRX_DATA == CHAR_NUL) begin
            tmr_clr_c = 1'b0;
          end else if (count_q < CNT_W'(MAX_LEN)) begin
            append_c = 1'b1;
          end else begin
            trunc_d = 1'b1;
            state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (iRX_VALID && is_term(iRX_DATA)) begin
            publish_c = 1'b1;
          end
        end
        default: begin
          // PUB lasts one cycle and accepts bytes exactly like IDLE.
          state_d = ST_IDLE;
          if (iRX_VALID && is_printable(iRX_DATA)) begin
            append_c = 1'b1;
            state_d  = ST_RECV;
          end
        end
      endcase

      if (append_c) begin
        work_d  = {work_q[WORK_W-9:0], iRX_DATA};
        count_d = count_q + CNT_W'(1);
      end

      if (publish_c) begin
        mess_d      = {1'b0, work_q};
        length_d    = count_q;
        ovf_d       = trunc_q;
        msg_valid_d = 1'b1;
        work_d      = '0;
        count_d     = '0;
        trunc_d     = 1'b0;
        state_d     = ST_PUB;
      end
    end

    busy_d = (state_d == ST_RECV) || (state_d == ST_DROP);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      mess_q      <= '0;
      length_q    <= '0;
      msg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      mess_q      <= mess_d;
      length_q    <= length_d;
      msg_valid_q <= msg_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign oMESS      = mess_q;
  assign oLENGTH    = length_q;
  assign oMSG_VALID = msg_valid_q;
  assign oBUSY      = busy_q;
  assign oOVERFLOW  = ovf_q;
  assign oERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_lcd_msg_assembler.sv
// Bench for lcd_msg_assembler: directed scenarios plus random byte streams, all outputs
// compared every cycle against a queue-based message model.
module tb_lcd_msg_assembler;

  localparam int unsigned MAX_LEN = 61;
  localparam int unsigned TMO     = 100;
  localparam int unsigned MW      = MAX_LEN * 8 + 1;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic [MW-1:0] mess;
  logic [8:0]    len;
  logic          msg_valid;
  logic          busy;
  logic          ovf;
  logic [7:0]    err_cnt;

  lcd_msg_assembler #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iRX_DATA   (rx_data),
    .iRX_VALID  (rx_valid),
    .iRX_ERR    (rx_err),
    .oMESS      (mess),
    .oLENGTH    (len),
    .oMSG_VALID (msg_valid),
    .oBUSY      (busy),
    .oOVERFLOW  (ovf),
    .oERR_CNT   (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_bad;

  // Reference model: the message in progress is a plain byte queue.
  byte unsigned  mq[$];
  bit            m_active;
  bit            m_drop;
  bit            m_trunc;
  int            m_idle;
  logic [MW-1:0] e_mess;
  int            e_len;
  bit            e_valid;
  bit            e_ovf;
  int            e_err;

  task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_prt(input logic [7:0] d);
    return !(d == 8'h0D || d == 8'h0A || d == 8'h08 || d == 8'h00);
  endfunction

  function automatic logic [MW-1:0] pack_msg();
    logic [MW-1:0] m;
    m = '0;
    foreach (mq[i]) m = (m << 8) | MW'(mq[i]);
    return m;
  endfunction

  task automatic drop_msg();
    mq.delete();
    m_active = 1'b0;
    m_drop   = 1'b0;
    m_trunc  = 1'b0;
    m_idle   = 0;
  endtask

  task automatic publish();
    e_mess  = pack_msg();
    e_len   = mq.size();
    e_ovf   = m_trunc;
    e_valid = 1'b1;
    drop_msg();
  endtask

  task automatic model_reset();
    drop_msg();
    e_mess  = '0;
    e_len   = 0;
    e_ovf   = 1'b0;
    e_valid = 1'b0;
    e_err   = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic e);
    e_valid = 1'b0;
    if (e) begin
      e_err = (e_err < 255) ? e_err + 1 : 255;
      drop_msg();
    end else if (!m_active) begin
      if (v && is_prt(d)) begin
        mq.push_back(d);
        m_active = 1'b1;
        m_idle   = 0;
      end
    end else if (v) begin
      if (d == 8'h0D || d == 8'h0A) begin
        publish();
      end else if (m_drop || d == 8'h00) begin
        m_idle = m_idle;
      end else if (d == 8'h08) begin
        void'(mq.pop_back());
        m_idle = 0;
        if (mq.size() == 0) m_active = 1'b0;
      end else if (mq.size() < MAX_LEN) begin
        mq.push_back(d);
        m_idle = 0;
      end else begin
        m_trunc = 1'b1;
        m_drop  = 1'b1;
      end
    end else if (!m_drop) begin
      if (m_idle == TMO - 1) publish();
      else m_idle++;
    end
  endtask

  task automatic check_outputs();
    chk_eq("mess", mess, e_mess);
    chk_eq("length", len, e_len);
    chk_eq("msg_valid", msg_valid, e_valid);
    chk_eq("busy", busy, m_active);
    chk_eq("overflow", ovf, e_ovf);
    chk_eq("err_cnt", err_cnt, e_err);
  endtask

  // One clock: drive away from the edge, let the DUT sample, then compare.
  task automatic step(input logic v, input logic [7:0] d, input logic e);
    rx_valid = v;
    rx_data  = d;
    rx_err   = e;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    model_step(v, d, e);
    check_outputs();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
  endtask

  logic [MW-1:0] prev_mess;
  int            hit;
  int            hit_len;
  int            npub;
  int unsigned   r;
  int unsigned   k;
  logic [7:0]    d;

  initial begin
    n_chk    = 0;
    n_bad    = 0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic CR-terminated message
    send_str("HI");
    step(1'b1, 8'h0D, 1'b0);
    chk_eq("t1_valid", msg_valid, 1'b1);
    chk_eq("t1_len", len, 9'd2);
    chk_eq("t1_lo", mess[15:0], 16'h4849);
    chk_eq("t1_hi", mess[MW-1:16], '0);
    chk_eq("t1_ovf", ovf, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Backspace edit, then a lone LF must not publish an empty message
    send_str("ABC");
    step(1'b1, 8'h08, 1'b0);
    send_str("D");
    step(1'b1, 8'h0A, 1'b0);
    chk_eq("t2_len", len, 9'd3);
    chk_eq("t2_lo", mess[23:0], 24'h414244);
    step(1'b1, 8'h0A, 1'b0);
    chk_eq("t2_nodup", msg_valid, 1'b0);

    // Overflow into DROP and truncated publish
    for (int i = 0; i < 65; i++) begin
      step(1'b1, 8'(8'h61 + i), 1'b0);
      chk_eq("t3_busy", busy, 1'b1);
    end
    step(1'b1, 8'h0D, 1'b0);
    chk_eq("t3_len", len, 9'd61);
    chk_eq("t3_last", mess[7:0], 8'h9D);
    chk_eq("t3_ovf", ovf, 1'b1);
    send_str("x");
    step(1'b1, 8'h0D, 1'b0);
    chk_eq("t3_ovf_clr", ovf, 1'b0);
    chk_eq("t3_len2", len, 9'd1);

    // Idle timeout latency, and no timeout while dropping
    send_str("OK");
    hit     = 0;
    hit_len = 0;
    for (int i = 1; i <= 120; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (msg_valid && hit == 0) begin
        hit     = i;
        hit_len = int'(len);
      end
    end
    chk_eq("t4_latency", hit, 100);
    chk_eq("t4_len", hit_len, 2);
    for (int i = 0; i < 62; i++) step(1'b1, 8'h71, 1'b0);
    npub = 0;
    for (int i = 0; i < 150; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (msg_valid) npub++;
    end
    chk_eq("t4_drop_nopub", npub, 0);
    chk_eq("t4_drop_busy", busy, 1'b1);
    step(1'b1, 8'h0D, 1'b0);
    chk_eq("t4_drop_ovf", ovf, 1'b1);

    // Error wins over a same-cycle byte and discards the message
    send_str("AB");
    prev_mess = mess;
    step(1'b1, 8'h43, 1'b1);
    step(1'b1, 8'h0D, 1'b0);
    chk_eq("t5_nopub", msg_valid, 1'b0);
    chk_eq("t5_errcnt", err_cnt, 8'd1);
    chk_eq("t5_keep", mess, prev_mess);
    for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1);
    chk_eq("t5_sat", err_cnt, 8'hFF);

    // Asynchronous reset mid-message
    send_str("XY");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_eq("t6_mess", mess, '0);
    chk_eq("t6_len", len, '0);
    chk_eq("t6_valid", msg_valid, 1'b0);
    chk_eq("t6_busy", busy, 1'b0);
    chk_eq("t6_ovf", ovf, 1'b0);
    chk_eq("t6_err", err_cnt, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_str("Z");
    step(1'b1, 8'h0D, 1'b0);
    chk_eq("t6_zlen", len, 9'd1);
    chk_eq("t6_zchar", mess[7:0], 8'h5A);

    // Random streams: frequent terminators first, then rare ones to reach overflow
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      d = 8'($urandom);
      if (r < 8) begin
        step(1'($urandom_range(0, 1)), d, 1'b1);
      end else if (r < 12) begin
        repeat ($urandom_range(95, 105)) step(1'b0, 8'h00, 1'b0);
      end else if (r < 400) begin
        step(1'b0, 8'h00, 1'b0);
      end else begin
        k = $urandom_range(0, 99);
        if (k < ((i < 1500) ? 10 : 1)) d = k[0] ? 8'h0D : 8'h0A;
        else if (k < 18) d = 8'h08;
        else if (k < 21) d = 8'h00;
        step(1'b1, d, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
